mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the IF/MEM stages and the memory. It issues one transaction at a time and drives per-port stall signals back into the pipeline. It also enforces a starvation bound on fetch and a response timeout.

## Interface
- MAX_STREAK, 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT, 255: cycles in WAIT without mem_rvalid before an error completion; 8-bit counter, range 1..255.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request, level.
- if_addr  in  32  fetch address.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetch data, valid with if_valid.
- d_req  in  1  data request, level.
- d_we  in  1  1 = store.
- d_be  in  4  byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_valid  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load data, valid with d_valid.
- stall_if  out  1  if_req && !if_valid, combinational.
- stall_mem  out  1  d_req && !d_valid, combinational.
- mem_req  out  1  transaction request to memory.
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/32/32  latched payload.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- bus_err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is present, choose an owner, latch its payload into the mem_* registers, and go to ISSUE. If no request is present, stay in IDLE.
- Selection: data wins by default. Fetch wins when only fetch requests, or when the streak counter equals MAX_STREAK.
- Streak counter:
  - Increments when data is granted while if_req=1.
  - Clears when fetch is granted.
  - Clears when data is granted with if_req=0.
  - Saturates at MAX_STREAK.
- ISSUE: hold mem_req=1 with the stable payload until mem_ready.
  - Store accepted: go to RESP.
  - Read accepted (fetch or load): go to WAIT and clear the timeout counter.
- WAIT: on mem_rvalid, capture mem_rdata and go to RESP.
  - Otherwise increment the timeout counter.
  - At TIMEOUT: set bus_err, load 32'hDEADBEEF as the response data, and go to RESP.
- RESP: pulse the owner's valid with the captured data (0 for stores), then go to IDLE. Requests are not sampled in RESP.
- Requesters hold req and payload stable until their valid pulse. They must drop or change req by the cycle after the pulse.
- mem_rvalid outside WAIT is ignored.
- Each memory owes a response only for its own accepted read.
- Reset:
  - State goes to IDLE; streak and timeout counters clear.
  - mem_req, if_valid, d_valid, bus_err = 0; all data outputs = 0.
  - Reset asserted mid-transaction abandons it; a late mem_rvalid is ignored.

## Timing
- Request sampled in IDLE at cycle T; mem_req high at T+1.
- Accept at T+1 (zero wait): store valid at T+2; read in WAIT from T+2.
- mem_rvalid arrives at least one cycle after acceptance. It is captured at the edge ending that cycle, and valid follows the next cycle. Best-case read: valid at T+3.
- Each mem_ready wait cycle adds one cycle. Each cycle mem_rvalid arrives later adds one cycle.
- Timeout completion: valid TIMEOUT+1 cycles after entering WAIT.
- Back-to-back: the next grant is sampled at T_valid+1, so a new transaction issues at T_valid+2.
- Simultaneous requests in IDLE resolve the same cycle; the loser stays stalled.
- stall_* are combinational from req and valid. There is no path from mem_* inputs to stall_*.

## Structure
- Shared package cpu_mem_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - owner encoding (OWN_IF = 0, OWN_D = 1);
  - ERR_DATA = 32'hDEADBEEF.
- Sub-module mem_arb_select: streak counter plus combinational winner selection. Inputs if_req, d_req, grant strobe; output owner.
- The top-level holds the FSM, payload and response registers, timeout counter, and bus_err.

## Test plan
- Isolated fetch: if_req at T, addr 0x40, mem_ready at once, mem_rvalid at T+3 with 0x00500093 -> if_valid at T+4, if_rdata 0x00500093, stall_if high T..T+3.
- Simultaneous if_req and d_req (load, 0x100) -> data granted first (mem_addr 0x100); fetch issues afterwards; stall_if held throughout.
- d_req held continuously with if_req pending, MAX_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data again.
- Store d_we=1, d_be=4'b0011, wdata 0x1234, mem_ready delayed 3 cycles -> mem_req high 4 cycles with stable payload; d_valid pulses the cycle after acceptance.
- Read with no mem_rvalid, TIMEOUT=8 -> d_valid with d_rdata 0xDEADBEEF and bus_err=1, held until reset.
- Reset asserted during WAIT, then mem_rvalid -> mem_req=0 and no valid pulse; next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// cpu_mem_pkg: shared types for the unified-memory port arbiter.
//   arb_state_t   - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   owner_t       - which pipeline port owns the current transaction
//   mem_payload_t - request payload latched at grant time
//   ERR_DATA      - response data returned on a read timeout
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_payload_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of every signal between the arbiter, the
// pipeline's IF/MEM ports and the unified memory.
//   master - arbiter view: takes pipeline requests and memory responses,
//            drives completions, stalls, the memory request and bus_err.
//   slave  - environment view (pipeline + memory), the mirror image.
interface mem_port_arbiter_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    // data port
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    // pipeline stalls
    logic        stall_if;
    logic        stall_mem;
    // memory side
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    // status
    logic        bus_err;

    modport master (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
        output stall_if, stall_mem,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output bus_err
    );

    modport slave (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
        input  stall_if, stall_mem,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  bus_err
    );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// mem_arb_select: picks the owner of the next memory transaction.
// Data wins by default; fetch wins when it is alone or when data has
// already taken MAX_STREAK grants in a row while fetch was waiting.
//   clock, reset - clock and synchronous active-high reset
//   if_req       - fetch request present
//   d_req        - data request present
//   grant        - a transaction is being granted to 'owner' this cycle
//   owner        - combinational winner
module mem_arb_select
    import cpu_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t owner
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    // Count of back-to-back data grants taken while fetch was waiting.
    logic [SW-1:0] streak_q;

    always_comb begin
        owner = OWN_D;
        if (if_req && (!d_req || streak_q == SW'(MAX_STREAK)))
            owner = OWN_IF;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            streak_q <= '0;
        end else if (grant) begin
            if (owner == OWN_IF || !if_req)
                streak_q <= '0;
            else if (streak_q != SW'(MAX_STREAK))
                streak_q <= streak_q + SW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch and data load/store. One transaction in flight at a time.
//   clock, reset - clock and synchronous active-high reset
//   bus          - pipeline ports, stalls, memory port and bus_err
//                  (see mem_port_arbiter_if, master modport)
// Parameters:
//   MAX_STREAK   - data grants allowed while fetch waits before fetch is forced
//   TIMEOUT      - WAIT cycles without mem_rvalid before an error completion (1..255)
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    arb_state_t   state_q, state_d;
    owner_t       owner_q, sel_owner;
    mem_payload_t pay_q;
    logic [31:0]  rdata_q;
    logic [7:0]   tmo_q;
    logic         bus_err_q;
    logic         grant;
    logic         resp_if, resp_d;

    mem_arb_select #(.MAX_STREAK(MAX_STREAK)) u_select (
        .clock  (clock),
        .reset  (reset),
        .if_req (bus.if_req),
        .d_req  (bus.d_req),
        .grant  (grant),
        .owner  (sel_owner)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Stores complete on acceptance; reads wait for data.
                if (bus.mem_ready) state_d = pay_q.we ? RESP : WAIT;
            end
            WAIT: begin
                if (bus.mem_rvalid || tmo_q == 8'(TIMEOUT)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Payload, response data, timeout counter and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q   <= OWN_IF;
            pay_q     <= '0;
            rdata_q   <= '0;
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q <= sel_owner;
                        if (sel_owner == OWN_IF)
                            pay_q <= '{we: 1'b0, be: 4'hF, addr: bus.if_addr, wdata: '0};
                        else
                            pay_q <= '{we: bus.d_we, be: bus.d_be, addr: bus.d_addr,
                                       wdata: bus.d_wdata};
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        tmo_q   <= '0;
                        rdata_q <= '0;  // stores respond with zero
                    end
                end
                WAIT: begin
                    // A real response wins over a timeout in the same cycle.
                    if (bus.mem_rvalid) begin
                        rdata_q <= bus.mem_rdata;
                    end else if (tmo_q == 8'(TIMEOUT)) begin
                        rdata_q   <= ERR_DATA;
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_if = (state_q == RESP) && (owner_q == OWN_IF);
    assign resp_d  = (state_q == RESP) && (owner_q == OWN_D);

    assign bus.if_valid  = resp_if;
    assign bus.if_rdata  = resp_if ? rdata_q : '0;
    assign bus.d_valid   = resp_d;
    assign bus.d_rdata   = resp_d ? rdata_q : '0;

    // Stalls depend only on request and the registered completion pulse.
    assign bus.stall_if  = bus.if_req && !resp_if;
    assign bus.stall_mem = bus.d_req && !resp_d;

    assign bus.mem_req   = (state_q == ISSUE);
    assign bus.mem_we    = pay_q.we;
    assign bus.mem_be    = pay_q.be;
    assign bus.mem_addr  = pay_q.addr;
    assign bus.mem_wdata = pay_q.wdata;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives the fetch/data ports and plays the memory.
// A transaction-level model predicts the winner of every grant, the
// payload seen on the memory port, the cycle of each completion and its
// data, the stalls and bus_err. Directed cases first, then random traffic.
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    int          streak;
    bit          exp_err;
    bit          f_pend;
    logic [31:0] f_addr;
    bit          dp;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive();
        bus.if_req  = f_pend;
        bus.if_addr = f_addr;
        bus.d_req   = dp;
        bus.d_we    = dwe;
        bus.d_be    = dbe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input bit mreq, input bit ifv, input bit dv);
        chk({tag, "_mem_req"},   32'(bus.mem_req),   32'(mreq));
        chk({tag, "_if_valid"},  32'(bus.if_valid),  32'(ifv));
        chk({tag, "_d_valid"},   32'(bus.d_valid),   32'(dv));
        chk({tag, "_stall_if"},  32'(bus.stall_if),  32'(f_pend && !ifv));
        chk({tag, "_stall_mem"}, 32'(bus.stall_mem), 32'(dp && !dv));
        chk({tag, "_bus_err"},   32'(bus.bus_err),   32'(exp_err));
    endtask

    // Called in an IDLE cycle with requests set up; returns in the RESP
    // cycle with the winner's request dropped.
    task automatic xact(input int k, input int lat, input bit to,
                        input logic [31:0] rd, output bit won_if);
        logic [31:0] exp_rd;
        bit          wif;
        drive();
        #1;
        chk_ctl("idle", 0, 0, 0);
        wif = f_pend && (!dp || streak == MAX_STREAK);
        if (wif)         streak = 0;
        else if (f_pend) streak = (streak < MAX_STREAK) ? streak + 1 : streak;
        else             streak = 0;
        won_if = wif;
        tick();
        for (int i = 0; i <= k; i++) begin
            chk_ctl("issue", 1, 0, 0);
            chk("addr", bus.mem_addr, wif ? f_addr : daddr);
            chk("we", 32'(bus.mem_we), wif ? 32'd0 : 32'(dwe));
            if (!wif) begin
                chk("be", 32'(bus.mem_be), 32'(dbe));
                chk("wdata", bus.mem_wdata, dwdata);
            end
            bus.mem_ready  = (i == k);
            bus.mem_rvalid = 1'($urandom_range(0, 1));  // ignored outside WAIT
            bus.mem_rdata  = $urandom;
            tick();
        end
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (!wif && dwe) begin
            exp_rd = 32'd0;
        end else if (to) begin
            for (int j = 0; j <= TIMEOUT; j++) begin
                chk_ctl("wait_to", 0, 0, 0);
                tick();
            end
            exp_rd  = 32'hDEADBEEF;
            exp_err = 1'b1;
        end else begin
            for (int j = 1; j < lat; j++) begin
                chk_ctl("wait", 0, 0, 0);
                tick();
            end
            chk_ctl("rvalid", 0, 0, 0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rd;
            tick();
            bus.mem_rvalid = 1'b0;
            exp_rd = rd;
        end
        chk_ctl("resp", 0, wif, !wif);
        chk("rdata", wif ? bus.if_rdata : bus.d_rdata, exp_rd);
        if (wif) f_pend = 1'b0;
        else     dp     = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        f_pend = 1'b0;
        dp     = 1'b0;
        drive();
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (2) tick();
        reset   = 1'b0;
        streak  = 0;
        exp_err = 1'b0;
        #1;
        chk_ctl("rst", 0, 0, 0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata",  bus.d_rdata,  32'd0);
    endtask

    task automatic new_data(input logic we, input logic [31:0] a);
        dp = 1'b1; dwe = we; dbe = 4'($urandom); daddr = a; dwdata = $urandom;
    endtask

    task automatic rand_reqs();
        if (!f_pend && $urandom_range(0, 2) != 0) begin
            f_pend = 1'b1;
            f_addr = ($urandom & 32'h0FFF_FFFC) | 32'h1000_0000;
        end
        if (!dp && $urandom_range(0, 2) != 0)
            new_data(1'($urandom_range(0, 1)), ($urandom & 32'h0FFF_FFFC) | 32'h2000_0000);
        drive();
    endtask

    bit         w;
    logic [5:0] exp_seq;

    initial begin
        f_addr = '0; dwe = 1'b0; dbe = '0; daddr = '0; dwdata = '0;
        do_reset();

        // isolated fetch
        f_pend = 1'b1; f_addr = 32'h40;
        xact(0, 2, 0, 32'h0050_0093, w);
        chk("iso_owner", 32'(w), 32'd1);
        tick();

        // simultaneous: data first, fetch afterwards
        f_pend = 1'b1; f_addr = 32'h80;
        new_data(1'b0, 32'h100);
        xact(0, 1, 0, $urandom, w);
        chk("sim_first", 32'(w), 32'd0);
        tick();
        xact(1, 3, 0, $urandom, w);
        chk("sim_second", 32'(w), 32'd1);
        tick();

        // store with delayed acceptance
        dp = 1'b1; dwe = 1'b1; dbe = 4'b0011; daddr = 32'h200; dwdata = 32'h1234;
        xact(3, 1, 0, 32'd0, w);
        tick();

        // starvation bound: D,D,D,D,I,D
        do_reset();
        exp_seq = 6'b01_0000;
        f_pend = 1'b1; f_addr = 32'h1000_0000;
        for (int i = 0; i < 6; i++) begin
            if (!dp) new_data(1'b0, 32'h2000_0000 + 32'(i * 4));
            xact(0, 1, 0, $urandom, w);
            chk($sformatf("streak_%0d", i), 32'(w), 32'(exp_seq[i]));
            tick();
        end

        // read timeout, bus_err sticky until reset
        new_data(1'b0, 32'h300);
        xact(1, 1, 1, 32'd0, w);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("err_hold", 0, 0, 0);
            tick();
        end
        do_reset();

        // reset during WAIT, late mem_rvalid ignored
        f_pend = 1'b1; f_addr = 32'h500;
        drive();
        tick();
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        reset  = 1'b1;
        f_pend = 1'b0;
        drive();
        tick();
        reset  = 1'b0;
        streak = 0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_0BAD;
        #1;
        chk_ctl("rst_wait", 0, 0, 0);
        tick();
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_ctl("rst_late", 0, 0, 0);
            tick();
        end
        f_pend = 1'b1; f_addr = 32'h504;
        xact(0, 1, 0, 32'hCAFE_F00D, w);
        tick();

        // random traffic
        repeat (300) begin
            rand_reqs();
            if (f_pend || dp) begin
                xact($urandom_range(0, 3), $urandom_range(1, 4), 0, $urandom, w);
                tick();
            end else begin
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                bus.mem_rdata  = $urandom;
                #1;
                chk_ctl("noreq", 0, 0, 0);
                tick();
                bus.mem_rvalid = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
